// File: rtl/fetch_queue_if.sv
// Instruction-memory read bus: fetch_queue drives it as master, the memory system answers as slave.
interface fetch_queue_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_cancel;
  logic               mem_done;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (output mem_rd, mem_addr, mem_cancel, input mem_done, mem_rdata);
  modport slave  (input mem_rd, mem_addr, mem_cancel, output mem_done, mem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding read feeding a DEPTH-entry prefetch queue to decode.
// Optional FETCH_BYPASS_EN: forward a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter int                 DEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 'h0800
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               halt_i,
  input  logic               br_valid_i,
  input  logic [ADDR_W-1:0]  br_pc_i,
  input  logic               dec_hold_i,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_next_pc_o,
  output logic               fetch_stall_o,
  fetch_queue_if.master      mem
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DRAIN = 2'd2} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0]  next_pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     head_q, tail_q;
  entry_t            fifo_q [DEPTH];
  logic              done, push, pop, bypass, q_valid, space;

  assign addr_inc = addr_q + ADDR_W'(2);
  assign done     = (state_q == S_WAIT) && mem.mem_done;
  assign q_valid  = (count_q != '0) && !br_valid_i;

`ifdef FETCH_BYPASS_EN
  assign bypass = (count_q == '0) && done && !br_valid_i && !dec_hold_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response is consumed directly, so it never occupies an entry.
  assign push = done && !br_valid_i && !bypass;
  assign pop  = q_valid && !dec_hold_i;

  always_comb begin
    count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    if (br_valid_i) count_d = '0;
  end
  assign space = (count_d < CW'(DEPTH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!br_valid_i && !halt_i && space) state_d = S_WAIT;
      S_WAIT: begin
        if (br_valid_i)        state_d = mem.mem_done ? S_IDLE : S_DRAIN;
        else if (mem.mem_done) state_d = (!halt_i && space) ? S_WAIT : S_IDLE;
      end
      // The read being cancelled must still complete; a redirect here only retargets fetch_pc.
      S_DRAIN: if (mem.mem_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_rd     = (state_q != S_IDLE);
    mem.mem_cancel = (state_q == S_DRAIN);
    mem.mem_addr   = addr_q;
    fetch_stall_o  = (count_q == '0) && (state_q != S_IDLE);
    out_valid_o    = q_valid;
    out_instr_o    = q_valid ? fifo_q[head_q].instr   : NOP_INSTR;
    out_next_pc_o  = q_valid ? fifo_q[head_q].next_pc : '0;
`ifdef FETCH_BYPASS_EN
    if (bypass) begin
      out_valid_o   = 1'b1;
      out_instr_o   = mem.mem_rdata;
      out_next_pc_o = addr_inc;
    end
`endif
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    if (br_valid_i) fetch_pc_d = br_pc_i;
    else if (done)  fetch_pc_d = addr_inc;
    // New read starts either from IDLE or back-to-back after a completed one.
    if (state_d == S_WAIT && (state_q == S_IDLE || done)) addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      if (br_valid_i) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PW'(1);
        if (pop)  head_q <= head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[tail_q] <= '{next_pc: addr_inc, instr: mem.mem_rdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory responder, expected-output scoreboard, negedge monitor.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, br_valid, dec_hold;
  logic [15:0] br_pc;
  logic        out_valid, fetch_stall;
  logic [15:0] out_instr, out_next_pc;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cnt = 0;
  bit stray = 1'b0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  fetch_queue_if #(.ADDR_W(16), .INSTR_W(16)) mbus ();

  fetch_queue dut (
    .clk_i(clk), .rst_ni(rst_n), .halt_i(halt), .br_valid_i(br_valid), .br_pc_i(br_pc),
    .dec_hold_i(dec_hold), .out_valid_o(out_valid), .out_instr_o(out_instr),
    .out_next_pc_o(out_next_pc), .fetch_stall_o(fetch_stall), .mem(mbus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [15:0] pc, input logic [15:0] instr);
    exp_q.push_back('{pc: pc, instr: instr});
  endtask

  // Memory: answers after `lat` extra cycles with addr ^ C3C3; `stray` forces one unsolicited strobe.
  initial begin
    mbus.mem_done  = 1'b0;
    mbus.mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mbus.mem_done = 1'b0;
      if (stray) begin
        mbus.mem_done  = 1'b1;
        mbus.mem_rdata = 16'hDEAD;
        stray = 1'b0;
      end else if (mbus.mem_rd) begin
        if (cnt == lat) begin
          mbus.mem_done  = 1'b1;
          mbus.mem_rdata = mbus.mem_addr ^ 16'hC3C3;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Scoreboard monitor: every instruction decode actually takes must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && !dec_hold) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected none", out_next_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if (out_next_pc !== e.pc || out_instr !== e.instr) begin
          failures++;
          $display("FAIL sb_entry: got pc %h instr %h expected pc %h instr %h",
                   out_next_pc, out_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; halt = 1'b0; br_valid = 1'b0; dec_hold = 1'b0; br_pc = '0;
    ticks(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 16'h0800);
    chk("rst_next_pc", out_next_pc, 0);
    chk("rst_mem_rd", mbus.mem_rd, 0);
    chk("rst_mem_addr", mbus.mem_addr, 0);
    chk("rst_cancel", mbus.mem_cancel, 0);
    chk("rst_stall", fetch_stall, 0);

    // Streaming with 1-cycle memory, then halt while WAIT
    expect_out(16'h0002, 16'hC3C3);
    expect_out(16'h0004, 16'hC3C1);
    expect_out(16'h0006, 16'hC3C7);
    expect_out(16'h0008, 16'hC3C5);
    rst_n = 1'b1;                        // cycle 0
    tick();                              // cycle 1
    chk("t1_first_rd", mbus.mem_rd, 1);
    chk("t1_first_addr", mbus.mem_addr, 16'h0000);
    chk("t1_stall", fetch_stall, 1);
    tick();                              // cycle 2
`ifndef FETCH_BYPASS_EN
    chk("t1_valid_c2", out_valid, 0);
`endif
    tick();                              // cycle 3
`ifndef FETCH_BYPASS_EN
    chk("t1_valid_c3", out_valid, 1);
`endif
    chk("t1_addr_c3", mbus.mem_addr, 16'h0002);
    ticks(4);                            // cycle 7
    halt = 1'b1;
    ticks(2);                            // cycle 9
    chk("t1_halt_rd", mbus.mem_rd, 0);
    tick();                              // cycle 10
    chk("t1_empty_valid", out_valid, 0);
    chk("t1_empty_nop", out_instr, 16'h0800);
    chk("t1_idle_stall", fetch_stall, 0);
    ticks(2);                            // cycle 12
    chk("t1_halt_still", mbus.mem_rd, 0);
    halt = 1'b0;
    tick();                              // cycle 13
    chk("t1_resume_addr", mbus.mem_addr, 16'h0008);
    chk("t1_resume_rd", mbus.mem_rd, 1);
    chk("t1_sb_drained", exp_q.size(), 0);

    // Reset mid-read, stray mem_done in IDLE, decode held for 10 cycles
    rst_n = 1'b0;
    #1;
    chk("t2_abort_rd", mbus.mem_rd, 0);
    tick();
    expect_out(16'h0002, 16'hC3C3);
    expect_out(16'h0004, 16'hC3C1);
    expect_out(16'h0006, 16'hC3C7);
    expect_out(16'h0008, 16'hC3C5);
    expect_out(16'h000A, 16'hC3CB);
    dec_hold = 1'b1;
    stray = 1'b1;
    rst_n = 1'b1;                        // cycle 0
    ticks(10);                           // cycle 10
    chk("t2_full_rd", mbus.mem_rd, 0);
    chk("t2_full_valid", out_valid, 1);
    chk("t2_head_pc", out_next_pc, 16'h0002);
    dec_hold = 1'b0;
    tick();                              // cycle 11
    chk("t2_refill_addr", mbus.mem_addr, 16'h0008);
    chk("t2_refill_rd", mbus.mem_rd, 1);
    halt = 1'b1;
    ticks(6);
    chk("t2_sb_drained", exp_q.size(), 0);

    // 5-cycle memory, redirect during WAIT, two redirects in one DRAIN
    rst_n = 1'b0;
    tick();
    lat = 5; halt = 1'b0;
    expect_out(16'h0402, 16'hC7C3);
    rst_n = 1'b1;                        // cycle 0
    ticks(2);                            // cycle 2
    br_valid = 1'b1; br_pc = 16'h0100;
    tick();                              // cycle 3
    br_valid = 1'b0;
    chk("t3_cancel", mbus.mem_cancel, 1);
    chk("t3_drain_addr", mbus.mem_addr, 16'h0000);
    chk("t3_drain_stall", fetch_stall, 1);
    ticks(4);                            // cycle 7
    chk("t3_idle_rd", mbus.mem_rd, 0);
    chk("t3_no_old", out_valid, 0);
    tick();                              // cycle 8
    chk("t3_target", mbus.mem_addr, 16'h0100);
    chk("t3_no_cancel", mbus.mem_cancel, 0);
    tick();                              // cycle 9
    br_valid = 1'b1; br_pc = 16'h0200;
    tick();                              // cycle 10
    br_valid = 1'b0;
    chk("t3_cancel2", mbus.mem_cancel, 1);
    tick();                              // cycle 11
    br_valid = 1'b1; br_pc = 16'h0300;
    tick();                              // cycle 12
    br_pc = 16'h0400;
    tick();                              // cycle 13
    br_valid = 1'b0;
    tick();                              // cycle 14
    chk("t3_idle2", mbus.mem_rd, 0);
    tick();                              // cycle 15
    chk("t3_last_wins", mbus.mem_addr, 16'h0400);
    tick();                              // cycle 16
    halt = 1'b1;
    ticks(8);
    chk("t3_sb_drained", exp_q.size(), 0);

    // Redirect coincident with mem_done, queue non-empty, address wrap
    rst_n = 1'b0;
    tick();
    lat = 1; halt = 1'b0; dec_hold = 1'b1;
    expect_out(16'h0000, 16'h3C3D);
    expect_out(16'h0002, 16'hC3C3);
    rst_n = 1'b1;                        // cycle 0
    ticks(6);                            // cycle 6: third response arrives
    br_valid = 1'b1; br_pc = 16'hFFFE;
    #2;
    chk("t4_br_valid", out_valid, 0);
    chk("t4_br_nop", out_instr, 16'h0800);
    tick();                              // cycle 7
    br_valid = 1'b0; dec_hold = 1'b0;
    chk("t4_flush_rd", mbus.mem_rd, 0);
    chk("t4_flush_valid", out_valid, 0);
    tick();                              // cycle 8
    chk("t4_wrap_addr", mbus.mem_addr, 16'hFFFE);
    ticks(2);                            // cycle 10
    chk("t4_wrap_next", mbus.mem_addr, 16'h0000);
    chk("t4_wrap_pc", out_next_pc, 16'h0000);
    halt = 1'b1;
    ticks(4);
    chk("t4_halt_rd", mbus.mem_rd, 0);
    chk("t4_sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
